// File: rtl/fetch_seq.sv
// fetch_seq: program-counter sequencer with RUN/WAIT_HI/WAIT_LO/HALT control; FETCH_SEQ_CALL_STACK_EN adds a one-entry return register.
// Latency: address is the PC register, one update per edge; handshake is seen 2 edges late; no backpressure (WAIT states stall the PC).
module fetch_seq #(
  parameter int Psize = 6,
  parameter int Osize = 6
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             branch_abs,
  input  logic             branch_rel,
  input  logic [Psize-1:0] target,
  input  logic [Osize-1:0] offset,
  input  logic             wait_req,
  input  logic             halt_req,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic             handshake,
  output logic [Psize-1:0] address,
  output logic             run,
  output logic             waiting,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t           state;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] off_ext;
  logic [Psize-1:0] pc_rel;
  logic             hs_meta;
  logic             hs_sync;

  assign address = pc;
  assign pc_inc  = pc + Psize'(1);
  // size cast of a signed operand sign-extends; the add wraps modulo 2^Psize
  assign off_ext = Psize'(signed'(offset));
  assign pc_rel  = pc + off_ext;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hs_meta <= 1'b0;
      hs_sync <= 1'b0;
    end else begin
      hs_meta <= handshake;
      hs_sync <= hs_meta;
    end
  end

`ifdef FETCH_SEQ_CALL_STACK_EN
  logic [Psize-1:0] ret_addr;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ret_addr <= '0;
    end else if (state == S_RUN && !halt_req && !wait_req && !ret_req && call_req) begin
      ret_addr <= pc_inc;
    end
  end
`else
  logic unused_ret_req;
  assign unused_ret_req = ret_req;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= S_RUN;
      pc      <= '0;
      run     <= 1'b1;
      waiting <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (halt_req) begin
            state   <= S_HALT;
            run     <= 1'b0;
            halted  <= 1'b1;
          end else if (wait_req) begin
            state   <= S_WAIT_HI;
            run     <= 1'b0;
            waiting <= 1'b1;
`ifdef FETCH_SEQ_CALL_STACK_EN
          end else if (ret_req) begin
            pc <= ret_addr;
          end else if (call_req || branch_abs) begin
            pc <= target;
`else
          end else if (call_req || branch_abs) begin
            pc <= target;
`endif
          end else if (branch_rel) begin
            pc <= pc_rel;
          end else begin
            pc <= pc_inc;
          end
        end
        S_WAIT_HI: begin
          if (hs_sync) begin
            state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!hs_sync) begin
            state   <= S_RUN;
            pc      <= pc_inc;
            run     <= 1'b1;
            waiting <= 1'b0;
          end
        end
        default: begin
          // HALT is left only through reset
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule
